// File: rtl/shifter_pkg.sv
// Shared types for the sequential shifter.
//   op_t    : shift operation encoding carried on the 2-bit op port
//   state_t : control FSM states (IDLE accepts, SHIFT iterates, DONE presents)
package shifter_pkg;

   typedef enum logic [1:0] {
      LSL = 2'b00,
      LSR = 2'b01,
      ASR = 2'b10,
      ROL = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of up to 2**KW-1 bit positions.
//   value   in  W   operand
//   op      in  2   LSL / LSR / ASR / ROL
//   k       in  KW  shift distance for this step
//   shifted out W   value shifted by k
module shift_step
   import shifter_pkg::*;
#(
   parameter int W  = 28,
   parameter int KW = 1
) (
   input  logic [W-1:0]  value,
   input  op_t           op,
   input  logic [KW-1:0] k,
   output logic [W-1:0]  shifted
);

   // Rotate: shift the doubled word and keep the upper half, so the bits
   // leaving the MSB end reappear at the LSB end.
   logic [2*W-1:0] w_dbl;
   assign w_dbl = {value, value} << k;

   always_comb begin
      shifted = value;
      case (op)
         LSL:     shifted = value << k;
         LSR:     shifted = value >> k;
         ASR:     shifted = $signed(value) >>> k;
         ROL:     shifted = w_dbl[2*W-1:W];
         default: shifted = value;
      endcase
   end

endmodule

// File: rtl/shifter_seq.sv
// Multi-cycle shifter: accepts one request, shifts it STEP bits per cycle
// on a WIDTH+GROW working register, then holds the result until consumed.
//   clk       in   clock
//   reset     in   async reset, active low
//   in_valid  in   request valid          in_ready  out  idle, can accept
//   entrada   in   WIDTH operand          op        in   00 LSL 01 LSR 10 ASR 11 ROL
//   amt       in   SHW shift amount
//   out_valid out  result valid           out_ready in   consumer accepts result
//   saida     out  WIDTH+GROW result      busy      out  operation in flight
module shifter_seq
   import shifter_pkg::*;
#(
   parameter int WIDTH = 26,
   parameter int GROW  = 2,
   parameter int STEP  = 1,
   parameter int SHW   = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        entrada,
   input  logic [1:0]              op,
   input  logic [SHW-1:0]          amt,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH+GROW-1:0]   saida,
   output logic                    busy
);

   localparam int OUT_W = WIDTH + GROW;
   localparam int KW    = $clog2(STEP + 1);

   state_t           r_state, w_state_nxt;
   op_t              r_op;
   logic [OUT_W-1:0] r_work;
   logic [SHW-1:0]   r_count;

   logic [OUT_W-1:0] w_shifted;
   logic [OUT_W-1:0] w_load;
   logic [KW-1:0]    w_k;
   logic             w_last;
   logic             w_accept;
   op_t              w_op_in;

   assign w_op_in  = op_t'(op);
   assign w_accept = in_valid && (r_state == IDLE);

   // Distance for this cycle: whatever remains, capped at STEP.
   always_comb begin
      if (r_count < SHW'(STEP)) w_k = r_count[KW-1:0];
      else                      w_k = KW'(STEP);
   end

   // This cycle's step exhausts the count.
   assign w_last = (r_count <= SHW'(STEP));

   // Sign-extend only for ASR so the first step already sees the sign in the
   // growth bits; every other op starts from a zero-extended operand.
   always_comb begin
      if (w_op_in == ASR) w_load = OUT_W'($signed(entrada));
      else                w_load = OUT_W'(entrada);
   end

   shift_step #(.W(OUT_W), .KW(KW)) u_step (
      .value   (r_work),
      .op      (r_op),
      .k       (w_k),
      .shifted (w_shifted)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = (amt != '0) ? SHIFT : DONE;
         end
         SHIFT: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_work  <= '0;
         r_count <= '0;
         r_op    <= LSL;
      end else if (w_accept) begin
         r_work  <= w_load;
         r_count <= amt;
         r_op    <= w_op_in;
      end else if (r_state == SHIFT) begin
         r_work  <= w_shifted;
         r_count <= r_count - SHW'(w_k);
      end
   end

   assign saida = r_work;

endmodule

// File: tb/tb_shifter_seq.sv
module tb_shifter_seq;
   localparam int W  = 26;
   localparam int OW = 28;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_valid4;
   logic [W-1:0]  entrada;
   logic [1:0]    op;
   logic [4:0]    amt;
   logic          out_ready;
   logic          in_ready, out_valid, busy;
   logic          in_ready4, out_valid4, busy4;
   logic [OW-1:0] saida, saida4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shifter_seq dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .entrada(entrada), .op(op), .amt(amt), .out_valid(out_valid),
      .out_ready(out_ready), .saida(saida), .busy(busy)
   );

   shifter_seq #(.STEP(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
      .entrada(entrada), .op(op), .amt(amt), .out_valid(out_valid4),
      .out_ready(out_ready), .saida(saida4), .busy(busy4)
   );

   // Reference: one whole shift on the extended operand by amt.
   function automatic logic [OW-1:0] model(logic [1:0] o, logic [W-1:0] e, int a);
      longint unsigned m, x, r;
      int rr;
      m = (64'd1 << OW) - 1;
      x = 64'(e);
      if (o == 2'b10 && e[W-1]) x = x | (m & ~((64'd1 << W) - 1));
      case (o)
         2'b00: r = (a >= OW) ? 0 : ((x << a) & m);
         2'b01: r = (a >= OW) ? 0 : (x >> a);
         2'b10: begin
            if (x[OW-1]) r = (a >= OW) ? m : ((x >> a) | (m & ~(m >> a)));
            else         r = (a >= OW) ? 0 : (x >> a);
         end
         default: begin
            rr = a % OW;
            r  = ((x << rr) | (x >> (OW - rr))) & m;
         end
      endcase
      return r[OW-1:0];
   endfunction

   function automatic int exp_cyc(int a, int step);
      return (a + step - 1) / step + 1;
   endfunction

   // Issue one request, return the result and cycles from accept to out_valid
   // (accept cycle counts as 1), then complete the handshake.
   task automatic run_op(input bit use4, input logic [1:0] o, input logic [W-1:0] e,
                         input logic [4:0] a, output logic [OW-1:0] res, output int cyc);
      int n;
      n = 0;
      @(negedge clk);
      op = o; entrada = e; amt = a;
      if (use4) in_valid4 = 1'b1; else in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_valid4 = 1'b0;
      entrada = W'($urandom); op = 2'($urandom); amt = 5'($urandom);
      while (((use4 ? out_valid4 : out_valid) !== 1'b1) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      cyc = n + 1;
      res = use4 ? saida4 : saida;
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0;
      entrada = '0; op = '0; amt = '0;
      #2;
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (saida !== '0)       begin errors++; $display("FAIL reset_saida got %h exp 0", saida); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
         errors++; $display("FAIL reset_dut4 got ov=%b ir=%b exp 0 1", out_valid4, in_ready4);
      end
      @(negedge clk) reset = 1'b1;
   endtask

   task automatic test_directed;
      logic [OW-1:0] res;
      logic [W-1:0]  e;
      int cyc;
      run_op(0, 2'b00, 26'h3FFFFFF, 5'd2, res, cyc);
      checks++; if (res !== 28'hFFFFFFC) begin errors++; $display("FAIL lsl2_value got %h exp FFFFFFC", res); end
      checks++; if (cyc != 3) begin errors++; $display("FAIL lsl2_latency got %0d exp 3", cyc); end
      // Bit 25 extends into bits 27:25 (E000000), then ASR by 4.
      run_op(0, 2'b10, 26'h2000000, 5'd4, res, cyc);
      checks++; if (res !== 28'hFE00000) begin errors++; $display("FAIL asr4_value got %h exp FE00000", res); end
      run_op(0, 2'b11, 26'h0000001, 5'd0, res, cyc);
      checks++; if (res !== 28'h0000001) begin errors++; $display("FAIL rol0_value got %h exp 0000001", res); end
      checks++; if (cyc != 1) begin errors++; $display("FAIL rol0_latency got %0d exp 1", cyc); end
      run_op(0, 2'b11, 26'h0000001, 5'd28, res, cyc);
      checks++; if (res !== 28'h0000001) begin errors++; $display("FAIL rol28_value got %h exp 0000001", res); end
      checks++; if (cyc != 29) begin errors++; $display("FAIL rol28_latency got %0d exp 29", cyc); end
      run_op(1, 2'b01, 26'h3FFFFFF, 5'd9, res, cyc);
      checks++; if (res !== 28'h001FFFF) begin errors++; $display("FAIL step4_lsr9_value got %h exp 001FFFF", res); end
      checks++; if (cyc != 4) begin errors++; $display("FAIL step4_lsr9_latency got %0d exp 4", cyc); end
      e = W'($urandom);
      run_op(0, 2'b00, e, 5'd2, res, cyc);
      checks++; if (res !== {e, 2'b00}) begin errors++; $display("FAIL grow_lsl2 got %h exp %h", res, {e, 2'b00}); end
      run_op(0, 2'b10, 26'h2000000, 5'd31, res, cyc);
      checks++; if (res !== 28'hFFFFFFF) begin errors++; $display("FAIL asr31_value got %h exp FFFFFFF", res); end
   endtask

   task automatic test_random;
      logic [OW-1:0] res, exp;
      logic [W-1:0]  e;
      logic [1:0]    o;
      logic [4:0]    a;
      int cyc;
      for (int i = 0; i < 60; i++) begin
         bit u4;
         u4 = (i >= 40);
         e  = W'($urandom);
         o  = 2'($urandom);
         a  = 5'($urandom_range(0, 31));
         exp = model(o, e, int'(a));
         run_op(u4, o, e, a, res, cyc);
         checks++; if (res !== exp) begin
            errors++; $display("FAIL rand_value op=%0d amt=%0d step4=%0d got %h exp %h", o, a, u4, res, exp);
         end
         checks++; if (cyc != exp_cyc(int'(a), u4 ? 4 : 1)) begin
            errors++; $display("FAIL rand_latency op=%0d amt=%0d step4=%0d got %0d exp %0d",
                               o, a, u4, cyc, exp_cyc(int'(a), u4 ? 4 : 1));
         end
      end
   endtask

   task automatic test_backpressure;
      logic [OW-1:0] held, exp2;
      logic [W-1:0]  e2;
      int n;
      @(negedge clk);
      op = 2'b00; entrada = 26'h1234567; amt = 5'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      held = saida;
      checks++; if (held !== model(2'b00, 26'h1234567, 3)) begin
         errors++; $display("FAIL bp_value got %h exp %h", held, model(2'b00, 26'h1234567, 3));
      end
      e2 = W'($urandom);
      exp2 = model(2'b01, e2, 0);
      @(negedge clk);
      in_valid = 1'b1; op = 2'b01; entrada = e2; amt = 5'd0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checks++; if (saida !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold cyc=%0d got saida=%h ov=%b ir=%b exp %h 1 0",
                               c, saida, out_valid, in_ready, held);
         end
      end
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_no_same_cycle_accept got ir=%b ov=%b exp 1 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || saida !== exp2) begin
         errors++; $display("FAIL bp_resume got ov=%b saida=%h exp 1 %h", out_valid, saida, exp2);
      end
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [OW-1:0] res;
      int cyc;
      bit seen;
      @(negedge clk);
      op = 2'b11; entrada = 26'h0ABCDEF; amt = 5'd20; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || saida !== '0) begin
         errors++; $display("FAIL midreset got ov=%b ir=%b busy=%b saida=%h exp 0 1 0 0",
                            out_valid, in_ready, busy, saida);
      end
      @(negedge clk) reset = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL midreset_stale got out_valid=1 exp none"); end
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
      run_op(0, 2'b01, 26'h3000000, 5'd5, res, cyc);
      checks++; if (res !== model(2'b01, 26'h3000000, 5) || cyc != 6) begin
         errors++; $display("FAIL post_reset_op got %h/%0d exp %h/6", res, cyc, model(2'b01, 26'h3000000, 5));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
